// File: rtl/eth_pkg.sv
// Shared types and header layout for the Galapagos Ethernet receive path.
// Lane offsets are bit positions within the 64-bit flit, with lane 0 at [7:0].
package eth_pkg;

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    PAYLOAD,
    DROP
  } rx_state_t;

  localparam int HDR_FLITS = 2;
  localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

  // Flit 0 fields.
  localparam int DST_LSB   = 0;
  localparam int SRC01_LSB = 48;
  // Flit 1 fields.
  localparam int SRC25_LSB = 0;
  localparam int ETYPE_LSB = 32;
  localparam int KDEST_LSB = 48;

  // Takes six bytes in wire order (first byte in [7:0]) and returns them big-endian.
  function automatic logic [47:0] byte_swap48(input logic [47:0] lanes);
    logic [47:0] be;
    be = '0;
    for (int i = 0; i < 6; i++) begin
      be[8*(5-i) +: 8] = lanes[8*i +: 8];
    end
    return be;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep registered AXI-Stream stage carrying data, keep, last and dest.
// Accepts a new beat whenever the register is empty or draining this cycle.
module axis_reg_slice #(
  parameter int DW  = 64,
  parameter int KW  = 8,
  parameter int DEW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  s_data,
  input  logic [KW-1:0]  s_keep,
  input  logic           s_last,
  input  logic [DEW-1:0] s_dest,
  input  logic           s_valid,
  output logic           s_ready,
  output logic [DW-1:0]  m_data,
  output logic [KW-1:0]  m_keep,
  output logic           m_last,
  output logic [DEW-1:0] m_dest,
  output logic           m_valid,
  input  logic           m_ready
);

  logic           valid_q, valid_d;
  logic [DW-1:0]  data_q, data_d;
  logic [KW-1:0]  keep_q, keep_d;
  logic           last_q, last_d;
  logic [DEW-1:0] dest_q, dest_d;

  assign s_ready = !valid_q || m_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    dest_d  = dest_q;
    if (s_ready) begin
      valid_d = s_valid;
      if (s_valid) begin
        data_d = s_data;
        keep_d = s_keep;
        last_d = s_last;
        dest_d = s_dest;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_last  = last_q;
  assign m_dest  = dest_q;

endmodule

// File: rtl/eth_rx_depacketizer.sv
// Parses the two-flit Galapagos Ethernet header, drops non-matching or runt
// frames, and forwards the payload through a registered egress stage.
module eth_rx_depacketizer
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02,
  parameter logic [15:0] ETHERTYPE     = 16'h88b5,
  parameter logic        ACCEPT_BCAST  = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tdest,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [47:0] m_src_mac,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  rx_state_t   state_q, state_d;
  logic [47:0] dst_q, dst_d;
  logic [15:0] src01_q, src01_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [7:0]  tdest_q, tdest_d;
  logic [15:0] ok_q, ok_d, drop_q, drop_d;
  logic        ok_inc, drop_inc;
  logic        slice_ready, xfer, hdr_match;
  logic [47:0] src_full;
  logic [15:0] etype;

  // Header flits are always consumed; only payload is subject to egress backpressure.
  assign s_axis_tready = (state_q == PAYLOAD) ? slice_ready : 1'b1;
  assign xfer          = s_axis_tvalid && s_axis_tready;

  assign src_full  = byte_swap48({s_axis_tdata[SRC25_LSB +: 32], src01_q});
  assign etype     = {s_axis_tdata[ETYPE_LSB +: 8], s_axis_tdata[ETYPE_LSB+8 +: 8]};
  assign hdr_match = ((dst_q == MAC_ADDR_FPGA) || (ACCEPT_BCAST && (dst_q == BCAST_MAC)))
                     && (etype == ETHERTYPE);

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    src01_d   = src01_q;
    src_mac_d = src_mac_q;
    tdest_d   = tdest_q;
    ok_inc    = 1'b0;
    drop_inc  = 1'b0;
    if (xfer) begin
      case (state_q)
        HDR0: begin
          dst_d   = byte_swap48(s_axis_tdata[DST_LSB +: 48]);
          src01_d = s_axis_tdata[SRC01_LSB +: 16];
          if (s_axis_tlast) drop_inc = 1'b1;
          else              state_d  = HDR1;
        end
        HDR1: begin
          if (s_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = HDR0;
          end else if (hdr_match) begin
            src_mac_d = src_full;
            tdest_d   = s_axis_tdata[KDEST_LSB +: 8];
            state_d   = PAYLOAD;
          end else begin
            state_d = DROP;
          end
        end
        PAYLOAD: begin
          if (s_axis_tlast) begin
            ok_inc  = 1'b1;
            state_d = HDR0;
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = HDR0;
          end
        end
        default: state_d = HDR0;
      endcase
    end
    ok_d   = (ok_inc && (ok_q != 16'hffff)) ? ok_q + 16'd1 : ok_q;
    drop_d = (drop_inc && (drop_q != 16'hffff)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= HDR0;
      dst_q     <= '0;
      src01_q   <= '0;
      src_mac_q <= '0;
      tdest_q   <= '0;
      ok_q      <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      src01_q   <= src01_d;
      src_mac_q <= src_mac_d;
      tdest_q   <= tdest_d;
      ok_q      <= ok_d;
      drop_q    <= drop_d;
    end
  end

  // Dest travels with each beat so a stalled last flit keeps its own tdest
  // while the next frame's header is already being parsed.
  axis_reg_slice #(.DW(64), .KW(8), .DEW(8)) u_egress (
    .clk     (aclk),
    .rst_n   (aresetn),
    .s_data  (s_axis_tdata),
    .s_keep  (s_axis_tkeep),
    .s_last  (s_axis_tlast),
    .s_dest  (tdest_q),
    .s_valid (s_axis_tvalid && (state_q == PAYLOAD)),
    .s_ready (slice_ready),
    .m_data  (m_axis_tdata),
    .m_keep  (m_axis_tkeep),
    .m_last  (m_axis_tlast),
    .m_dest  (m_axis_tdest),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign m_src_mac      = src_mac_q;
  assign frames_ok      = ok_q;
  assign frames_dropped = drop_q;

endmodule

// File: tb/tb_eth_rx_depacketizer.sv
// Directed bench for eth_rx_depacketizer: header checks, drops, runts,
// broadcast acceptance, backpressure, back-to-back frames and async reset.
module tb_eth_rx_depacketizer;

  localparam logic [63:0] F0_GOOD = 64'hc40c02ca553e16fa;
  localparam logic [63:0] F0_BADD = 64'hc40c02ca553e16fb;
  localparam logic [63:0] F0_BC   = 64'hc40cffffffffffff;
  localparam logic [63:0] F1_GOOD = 64'h0003b58847c0887a;
  localparam logic [63:0] F1_BADE = 64'h0003000847c0887a;
  localparam logic [63:0] F1_D11  = 64'h0011b58847c0887a;
  localparam logic [63:0] F1_D22  = 64'h0022b58847c0887a;
  localparam logic [63:0] P0      = 64'h0100000100030000;
  localparam logic [63:0] P1      = 64'h5073930200000000;
  localparam logic [47:0] SRC_MAC = 48'h0cc47a88c047;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic [7:0]  m_tdest;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [47:0] m_src_mac;
  logic [15:0] frames_ok, frames_dropped;

  // Second instance with broadcast acceptance disabled; only fed during the broadcast test.
  logic        en1 = 1'b0;
  logic        b_tready, b_tlast, b_tvalid;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep, b_tdest;
  logic [47:0] b_src_mac;
  logic [15:0] b_ok, b_dropped;

  int n_checks = 0;
  int n_fail = 0;
  int out_cnt = 0;
  int bp_mode = 0;
  logic [80:0] exp_q[$];
  logic [63:0] pay_d [32];
  logic [7:0]  pay_k [32];

  always #5 aclk = ~aclk;

  eth_rx_depacketizer dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tdest(m_tdest), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_src_mac(m_src_mac), .frames_ok(frames_ok), .frames_dropped(frames_dropped)
  );

  eth_rx_depacketizer #(.ACCEPT_BCAST(1'b0)) dut_nobc (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid && en1), .s_axis_tready(b_tready),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tlast(b_tlast),
    .m_axis_tdest(b_tdest), .m_axis_tvalid(b_tvalid), .m_axis_tready(1'b1),
    .m_src_mac(b_src_mac), .frames_ok(b_ok), .frames_dropped(b_dropped)
  );

  // Egress ready: 0 = always high, 1 = random, 2 = held low.
  always @(posedge aclk) begin
    #1;
    case (bp_mode)
      1:       m_tready = 1'($urandom_range(0, 1));
      2:       m_tready = 1'b0;
      default: m_tready = 1'b1;
    endcase
  end

  // Scoreboard: every egress transfer must match the head of exp_q; stalled beats must hold.
  logic        prev_stall = 1'b0;
  logic [81:0] prev_snap = '0;
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest} !== prev_snap) begin
          n_fail++;
          $display("FAIL stall_stable got %h required %h", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest}, prev_snap);
        end
      end
      if (m_tvalid && m_tready) begin
        out_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL egress_unexpected got %h required no beat", {m_tdata, m_tkeep, m_tlast, m_tdest});
        end else begin
          logic [80:0] e;
          e = exp_q.pop_front();
          if ({m_tdata, m_tkeep, m_tlast, m_tdest} !== e) begin
            n_fail++;
            $display("FAIL egress_beat got %h required %h", {m_tdata, m_tkeep, m_tlast, m_tdest}, e);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_snap  = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest};
    end
  end

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    en1      = 1'b0;
    bp_mode  = 0;
    exp_q.delete();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  // Presents one flit and returns just after the edge on which it transferred.
  task automatic send_flit(input logic [63:0] d, input logic [7:0] k, input logic l, output int stalls);
    bit done;
    stalls   = 0;
    done     = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge aclk);
      if (s_tready) done = 1;
      else stalls++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL ingress_timeout got tready=0 required a transfer within 1000 cycles");
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f0, input logic [63:0] f1, input int npay,
                            input logic fwd, input logic [7:0] dest, output int stalls);
    int w;
    stalls = 0;
    send_flit(f0, 8'hff, 1'b0, w);
    stalls += w;
    send_flit(f1, 8'hff, 1'b0, w);
    stalls += w;
    for (int i = 0; i < npay; i++) begin
      if (fwd) exp_q.push_back({pay_d[i], pay_k[i], 1'(i == npay - 1), dest});
      send_flit(pay_d[i], pay_k[i], 1'(i == npay - 1), w);
      stalls += w;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge aclk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d beats outstanding required 0", exp_q.size());
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic load_short_payload();
    pay_d[0] = P0; pay_k[0] = 8'hff;
    pay_d[1] = P1; pay_k[1] = 8'h0f;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest} !== 82'd0) begin
      n_fail++;
      $display("FAIL reset_egress got %h required 0", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest});
    end
    n_checks++;
    if ({m_src_mac, frames_ok, frames_dropped} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_regs got %h required 0", {m_src_mac, frames_ok, frames_dropped});
    end
    n_checks++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready got %b required 1", s_tready);
    end
  endtask

  task automatic test_good_frame();
    int w;
    do_reset();
    exp_q.push_back({P0, 8'hff, 1'b0, 8'h03});
    exp_q.push_back({P1, 8'h0f, 1'b1, 8'h03});
    send_flit(F0_GOOD, 8'hff, 1'b0, w);
    send_flit(F1_GOOD, 8'hff, 1'b0, w);
    send_flit(P0, 8'hff, 1'b0, w);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== P0) begin
      n_fail++;
      $display("FAIL latency got valid=%b data=%h required valid=1 data=%h", m_tvalid, m_tdata, P0);
    end
    send_flit(P1, 8'h0f, 1'b1, w);
    wait_drain();
    n_checks++;
    if (m_tdest !== 8'h03) begin
      n_fail++;
      $display("FAIL good_tdest got %h required 03", m_tdest);
    end
    n_checks++;
    if (m_src_mac !== SRC_MAC) begin
      n_fail++;
      $display("FAIL good_src_mac got %h required %h", m_src_mac, SRC_MAC);
    end
    n_checks++;
    if (frames_ok !== 16'd1 || frames_dropped !== 16'd0) begin
      n_fail++;
      $display("FAIL good_counters got ok=%0d drop=%0d required ok=1 drop=0", frames_ok, frames_dropped);
    end
  endtask

  task automatic test_bad_dst();
    int st, w, base;
    do_reset();
    load_short_payload();
    base = out_cnt;
    send_frame(F0_BADD, F1_GOOD, 2, 1'b0, 8'h00, st);
    repeat (2) @(posedge aclk);
    #1;
    n_checks++;
    if (st != 0 || out_cnt != base) begin
      n_fail++;
      $display("FAIL bad_dst_quiet got stalls=%0d beats=%0d required 0 and 0", st, out_cnt - base);
    end
    n_checks++;
    if (frames_dropped !== 16'd1 || frames_ok !== 16'd0) begin
      n_fail++;
      $display("FAIL bad_dst_counters got drop=%0d ok=%0d required drop=1 ok=0", frames_dropped, frames_ok);
    end
    send_frame(F0_GOOD, F1_GOOD, 2, 1'b1, 8'h03, w);
    wait_drain();
    n_checks++;
    if (frames_ok !== 16'd1 || frames_dropped !== 16'd1) begin
      n_fail++;
      $display("FAIL after_drop_counters got ok=%0d drop=%0d required ok=1 drop=1", frames_ok, frames_dropped);
    end
  endtask

  task automatic test_bad_ethertype();
    int st;
    do_reset();
    load_short_payload();
    send_frame(F0_GOOD, F1_BADE, 2, 1'b0, 8'h00, st);
    repeat (2) @(posedge aclk);
    #1;
    n_checks++;
    if (frames_dropped !== 16'd1 || frames_ok !== 16'd0 || st != 0) begin
      n_fail++;
      $display("FAIL bad_etype got drop=%0d ok=%0d stalls=%0d required drop=1 ok=0 stalls=0", frames_dropped, frames_ok, st);
    end
  endtask

  task automatic test_broadcast();
    int st;
    do_reset();
    load_short_payload();
    en1 = 1'b1;
    send_frame(F0_BC, F1_GOOD, 2, 1'b1, 8'h03, st);
    wait_drain();
    en1 = 1'b0;
    n_checks++;
    if (frames_ok !== 16'd1 || frames_dropped !== 16'd0) begin
      n_fail++;
      $display("FAIL bcast_accept got ok=%0d drop=%0d required ok=1 drop=0", frames_ok, frames_dropped);
    end
    n_checks++;
    if (b_dropped !== 16'd1 || b_ok !== 16'd0) begin
      n_fail++;
      $display("FAIL bcast_reject got drop=%0d ok=%0d required drop=1 ok=0", b_dropped, b_ok);
    end
  endtask

  task automatic test_runt();
    int w, base;
    do_reset();
    load_short_payload();
    base = out_cnt;
    send_flit(F0_GOOD, 8'hff, 1'b1, w);
    n_checks++;
    if (frames_dropped !== 16'd1 || frames_ok !== 16'd0) begin
      n_fail++;
      $display("FAIL runt0 got drop=%0d ok=%0d required drop=1 ok=0", frames_dropped, frames_ok);
    end
    send_flit(F0_GOOD, 8'hff, 1'b0, w);
    send_flit(F1_GOOD, 8'hff, 1'b1, w);
    repeat (2) @(posedge aclk);
    #1;
    n_checks++;
    if (frames_dropped !== 16'd2 || out_cnt != base) begin
      n_fail++;
      $display("FAIL runt1 got drop=%0d beats=%0d required drop=2 beats=0", frames_dropped, out_cnt - base);
    end
    send_frame(F0_GOOD, F1_GOOD, 2, 1'b1, 8'h03, w);
    wait_drain();
    n_checks++;
    if (frames_ok !== 16'd1) begin
      n_fail++;
      $display("FAIL runt_recover got ok=%0d required 1", frames_ok);
    end
  endtask

  task automatic test_back_to_back();
    int st, base;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pay_d[i] = {8'(i), 24'h5a5a5a, 32'(i * 7 + 1)};
      pay_k[i] = (i == 19) ? 8'h3f : 8'hff;
    end
    base = out_cnt;
    bp_mode = 1;
    send_frame(F0_GOOD, F1_D11, 20, 1'b1, 8'h11, st);
    for (int i = 0; i < 3; i++) begin
      pay_d[i] = {32'hbeef0000, 32'(i)};
      pay_k[i] = (i == 2) ? 8'h01 : 8'hff;
    end
    send_frame(F0_GOOD, F1_D22, 3, 1'b1, 8'h22, st);
    wait_drain();
    bp_mode = 0;
    n_checks++;
    if (out_cnt - base != 23) begin
      n_fail++;
      $display("FAIL bp_beat_count got %0d required 23", out_cnt - base);
    end
    n_checks++;
    if (frames_ok !== 16'd2 || frames_dropped !== 16'd0) begin
      n_fail++;
      $display("FAIL b2b_counters got ok=%0d drop=%0d required ok=2 drop=0", frames_ok, frames_dropped);
    end
  endtask

  // Runs after test_back_to_back without a reset so counters and src MAC are nonzero.
  task automatic test_reset_mid();
    int w;
    bp_mode = 2;
    pay_d[0] = P0;
    pay_k[0] = 8'hff;
    send_flit(F0_GOOD, 8'hff, 1'b0, w);
    send_flit(F1_GOOD, 8'hff, 1'b0, w);
    send_flit(P0, 8'hff, 1'b0, w);
    n_checks++;
    if (m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_valid got %b required 1", m_tvalid);
    end
    #2 aresetn = 1'b0;
    #1;
    n_checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest, m_src_mac, frames_ok, frames_dropped} !== 162'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear got %h required 0",
               {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest, m_src_mac, frames_ok, frames_dropped});
    end
    do_reset();
    load_short_payload();
    send_frame(F0_GOOD, F1_GOOD, 2, 1'b1, 8'h03, w);
    wait_drain();
    n_checks++;
    if (frames_ok !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_recover got ok=%0d required 1", frames_ok);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_dst();
    test_bad_ethertype();
    test_broadcast();
    test_runt();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion required finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eth_rx_depacketizer.md
# eth_rx_depacketizer

Receive-side counterpart of the Ethernet stimulus/packetizer path. It consumes 64-bit AXI-Stream Ethernet frames from the MAC side, captures and checks the 16-byte Galapagos Ethernet header (destination MAC, source MAC, ethertype, kernel destination), and forwards the flit-aligned payload to the kernel fabric with the destination on `m_axis_tdest`. Frames that fail the checks are discarded, and accept/drop counters are kept.

## Interface
- `MAC_ADDR_FPGA`, 48'hfa163e55ca02: local MAC; frames to any other unicast destination are dropped.
- `ETHERTYPE`, 16'h88b5: required ethertype.
- `ACCEPT_BCAST`, 1'b1: also accept destination ff:ff:ff:ff:ff:ff.
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 64: ingress data. Byte lane i is `[8i+7:8i]`, and lane 0 is first on the wire.
- `s_axis_tkeep` in 8: ingress byte enables.
- `s_axis_tlast` in 1: last flit of the frame.
- `s_axis_tvalid` in 1: ingress valid.
- `s_axis_tready` out 1: ingress ready.
- `m_axis_tdata` out 64: payload data.
- `m_axis_tkeep` out 8: payload byte enables.
- `m_axis_tlast` out 1: last payload flit.
- `m_axis_tdest` out 8: kernel destination, constant for the whole frame.
- `m_axis_tvalid` out 1: egress valid.
- `m_axis_tready` in 1: egress ready.
- `m_src_mac` out 48: source MAC of the frame currently being forwarded.
- `frames_ok` out 16: count of accepted frames; saturates.
- `frames_dropped` out 16: count of dropped frames (mismatch plus runt); saturates.

## Operation
- Header layout (two flits, on-wire byte order, multi-byte fields big-endian):
  - Flit 0: lanes 0–5 hold the destination MAC (lane 0 is the MSB); lanes 6–7 hold source MAC bytes 0–1.
  - Flit 1: lanes 0–3 hold source MAC bytes 2–5; lanes 4–5 hold the ethertype; lane 6 holds the kernel destination; lane 7 is reserved and ignored.
- Payload starts at flit 2 and is forwarded unmodified: data, keep and last pass straight through.
- Header flit `tkeep` is not checked.
- State machine, with a transfer meaning `s_axis_tvalid && s_axis_tready`:
  - `HDR0`: on transfer, latch the destination MAC and source bytes 0–1. If `tlast` is set, count a runt, increment `frames_dropped` and stay in `HDR0`; otherwise go to `HDR1`.
  - `HDR1`: on transfer, latch the rest of the header.
    - `tlast` set: count a runt and go to `HDR0`.
    - Destination matches (`MAC_ADDR_FPGA`, or broadcast when `ACCEPT_BCAST`) and ethertype matches: load `m_axis_tdest` and `m_src_mac`, then go to `PAYLOAD`.
    - Otherwise: go to `DROP`.
  - `PAYLOAD`: forward each flit. On the transfer carrying `tlast`, increment `frames_ok` and go to `HDR0`.
  - `DROP`: consume flits without forwarding. On `tlast`, increment `frames_dropped` and go to `HDR0`.
- `s_axis_tready`:
  - Forced to 1 in `HDR0`, `HDR1` and `DROP`.
  - In `PAYLOAD` it equals `!m_axis_tvalid || m_axis_tready`.
- Counters saturate at 16'hffff. Both can never increment in the same cycle.
- Reset values: state `HDR0`; all `m_axis_*` outputs, `m_src_mac` and both counters are 0.
- Reset mid-frame aborts the frame. The next ingress flit is parsed as a header, so the upstream MAC must be reset together with this block.

## Timing
- Output is a single registered stage. Latency from a payload flit's ingress transfer to `m_axis_tvalid` is 1 cycle.
- Throughput is 1 flit/cycle with `m_axis_tready` held high. Header overhead is 2 ingress cycles and produces no egress bubble beyond that.
- `m_axis_*` stay stable while `tvalid && !tready`. `tvalid` never drops without a completed transfer.
- `m_axis_tdest` and `m_src_mac` are updated only on the `HDR1` to `PAYLOAD` transition. They hold until the next accepted header.
- The `HDR0` transfer following a `PAYLOAD` `tlast` may occur in the same cycle the egress register holds that last flit. Back-to-back frames therefore have no idle cycle.
- Counters update on the clock edge of the terminating transfer and are visible the next cycle.

## Structure
- `eth_pkg` holds:
  - the state enum `rx_state_t` (`HDR0`, `HDR1`, `PAYLOAD`, `DROP`);
  - localparams for header lane offsets, `HDR_FLITS=2` and `BCAST_MAC`;
  - a `byte_swap48` function for MAC extraction.
- One sub-module, `axis_reg_slice`: a one-deep registered AXIS stage with data/keep/last/dest, instantiated for the egress path.

## Test plan
- Good frame:
  - Stimulus: flit0 = 64'hc40c02ca553e16fa, flit1 = 64'h0003b58847c0887a, then payload 64'h0100000100030000 (keep ff) and 64'h5073930200000000 (keep 0f, last).
  - Response: two egress flits identical to the payload, `tdest`=8'h03, `m_src_mac`=48'h0cc47a88c047, `frames_ok`=1.
- Wrong destination MAC (lane 0 = 8'hfb):
  - Response: no egress activity, `s_axis_tready` stays 1, `frames_dropped`=1.
  - A following good frame is still forwarded.
- Wrong ethertype (lanes 4–5 = 08 00): frame dropped, `frames_dropped`=1.
- Broadcast destination ff..ff:
  - `ACCEPT_BCAST`=1: frame forwarded.
  - `ACCEPT_BCAST`=0: frame dropped.
- Runt frames:
  - `tlast` on flit0: `frames_dropped`=1, state returns to `HDR0`.
  - `tlast` on flit1: `frames_dropped`=2.
  - No egress in either case.
- Backpressure: random `m_axis_tready` over a 20-flit payload.
  - Response: all payload flits in order, no loss or duplication, egress signals stable while stalled.
  - Back-to-back frames complete with `frames_ok`=2.
  - Asserting `aresetn` low mid-payload clears all outputs immediately.
